// File: rtl/counter_arb_pkg.sv
// Shared definitions for the counter access arbiter: FSM state encoding,
// default parameter values and a small constant helper.
package counter_arb_pkg;

  localparam int unsigned DEF_N_REQ          = 3;
  localparam int unsigned DEF_LOCKOUT_CYCLES = 16;
  localparam int unsigned DEF_ACK_TIMEOUT    = 255;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_HOLD  = 2'd2
  } arb_state_t;

  // Larger of two constants, used to size the shared cycle counter.
  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/req_edge_detect.sv
// Per-bit rising-edge detector for the request levels.
// Ports:
//   clk, reset   clock and asynchronous active-high reset
//   level        request levels (already synchronized/debounced)
//   rise_c       combinational rising-edge vector: level & ~prev
// The history register resets to all ones so a level held high through
// reset release does not look like a fresh request.
module req_edge_detect #(
  parameter int unsigned WIDTH = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] level,
  output logic [WIDTH-1:0] rise_c
);

  logic [WIDTH-1:0] prev_q;

  // Previous-cycle sample of the levels.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) prev_q <= '1;
    else       prev_q <= level;
  end

  assign rise_c = level & ~prev_q;

endmodule

// File: rtl/counter_access_arbiter.sv
// Round-robin arbiter serializing button requests into single commands
// toward a shared counter, with ack timeout and post-command lockout.
// Ports:
//   clk, reset    clock and asynchronous active-high reset
//   req_i         per-requester request levels
//   cmd_valid_o   command valid toward the counter
//   cmd_id_o      granted requester index
//   cmd_ack_i     counter accepted the command (only honoured in ISSUE)
//   grant_o       one-hot of cmd_id_o, zero when no command is valid
//   busy_o        high whenever the FSM is not IDLE
//   overrun_o     pulse: new edge on a requester already pending
//   timeout_o     pulse: command aborted because no ack arrived
// Build option: define CLEAR_PRIORITY_EN to give requester 0 absolute
// priority in IDLE; the others keep rotating among themselves.
module counter_access_arbiter
  import counter_arb_pkg::*;
#(
  parameter int unsigned N_REQ          = DEF_N_REQ,
  parameter int unsigned LOCKOUT_CYCLES = DEF_LOCKOUT_CYCLES,
  parameter int unsigned ACK_TIMEOUT    = DEF_ACK_TIMEOUT
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [N_REQ-1:0]           req_i,
  output logic                       cmd_valid_o,
  output logic [$clog2(N_REQ)-1:0]   cmd_id_o,
  input  logic                       cmd_ack_i,
  output logic [N_REQ-1:0]           grant_o,
  output logic                       busy_o,
  output logic                       overrun_o,
  output logic                       timeout_o
);

  localparam int unsigned ID_W      = $clog2(N_REQ);
  localparam int unsigned CNT_MAX   = max_u(ACK_TIMEOUT, LOCKOUT_CYCLES);
  localparam int unsigned CNT_W     = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX);
  localparam int unsigned ACK_LAST  = ACK_TIMEOUT - 1;
  localparam int unsigned HOLD_LAST = (LOCKOUT_CYCLES == 0) ? 0 : LOCKOUT_CYCLES - 1;

  arb_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [N_REQ-1:0] pending_q, pending_d;
  logic [ID_W-1:0]  last_grant_q, last_grant_d;
  logic [N_REQ-1:0] req_rise;
  logic [N_REQ-1:0] clr_vec;
  logic [ID_W-1:0]  rr_winner;
  logic             cmd_valid_d, busy_d, overrun_d, timeout_d;
  logic [ID_W-1:0]  cmd_id_d;
  logic [N_REQ-1:0] grant_d;

  req_edge_detect #(
    .WIDTH (N_REQ)
  ) u_edge (
    .clk    (clk),
    .reset  (reset),
    .level  (req_i),
    .rise_c (req_rise)
  );

  // Winner search: first pending index upward from last_grant+1, wrapping.
  always_comb begin
    int unsigned idx;
    logic        found;
    rr_winner = last_grant_q;
    found     = 1'b0;
    idx       = 0;
    for (int unsigned off = 1; off <= N_REQ; off++) begin
      idx = 32'(last_grant_q) + off;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!found && pending_q[ID_W'(idx)]) begin
        rr_winner = ID_W'(idx);
        found     = 1'b1;
      end
    end
`ifdef CLEAR_PRIORITY_EN
    // Requester 0 overrides rotation; with bit 0 clear the search above
    // already rotates over the remaining requesters only.
    if (pending_q[0]) rr_winner = '0;
`else
`endif
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    cmd_valid_d  = cmd_valid_o;
    cmd_id_d     = cmd_id_o;
    timeout_d    = 1'b0;
    clr_vec      = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (|pending_q) begin
          state_d     = ST_ISSUE;
          cnt_d       = '0;
          cmd_valid_d = 1'b1;
          cmd_id_d    = rr_winner;
        end
      end
      ST_ISSUE: begin
        // An ack on the final allowed cycle still counts as accepted.
        if (cmd_ack_i || (cnt_q == CNT_W'(ACK_LAST))) begin
          timeout_d    = ~cmd_ack_i;
          clr_vec      = N_REQ'(1) << cmd_id_o;
          last_grant_d = cmd_id_o;
          cmd_valid_d  = 1'b0;
          cnt_d        = '0;
          state_d      = (LOCKOUT_CYCLES == 0) ? ST_IDLE : ST_HOLD;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_HOLD: begin
        if (cnt_q == CNT_W'(HOLD_LAST)) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d     = ST_IDLE;
        cnt_d       = '0;
        cmd_valid_d = 1'b0;
      end
    endcase

    // New edges win over the clear of the command just finished.
    pending_d = (pending_q & ~clr_vec) | req_rise;
    overrun_d = |(req_rise & pending_q);
    busy_d    = (state_d != ST_IDLE);
    grant_d   = cmd_valid_d ? (N_REQ'(1) << cmd_id_d) : '0;
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      pending_q    <= '0;
      last_grant_q <= ID_W'(N_REQ - 1);
      cmd_valid_o  <= 1'b0;
      cmd_id_o     <= '0;
      grant_o      <= '0;
      busy_o       <= 1'b0;
      overrun_o    <= 1'b0;
      timeout_o    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      pending_q    <= pending_d;
      last_grant_q <= last_grant_d;
      cmd_valid_o  <= cmd_valid_d;
      cmd_id_o     <= cmd_id_d;
      grant_o      <= grant_d;
      busy_o       <= busy_d;
      overrun_o    <= overrun_d;
      timeout_o    <= timeout_d;
    end
  end

endmodule

// File: tb/tb_counter_access_arbiter.sv
// Scoreboard bench for counter_access_arbiter with default parameters.
module tb_counter_access_arbiter;

  logic       clk;
  logic       reset;
  logic [2:0] req_i;
  logic       cmd_valid_o;
  logic [1:0] cmd_id_o;
  logic       cmd_ack_i;
  logic [2:0] grant_o;
  logic       busy_o;
  logic       overrun_o;
  logic       timeout_o;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_q[$];
  logic prev_valid = 1'b0;

  counter_access_arbiter dut (
    .clk         (clk),
    .reset       (reset),
    .req_i       (req_i),
    .cmd_valid_o (cmd_valid_o),
    .cmd_id_o    (cmd_id_o),
    .cmd_ack_i   (cmd_ack_i),
    .grant_o     (grant_o),
    .busy_o      (busy_o),
    .overrun_o   (overrun_o),
    .timeout_o   (timeout_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every new command is compared against the next expected id.
  initial begin
    forever begin
      @(negedge clk);
      if (cmd_valid_o && !prev_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_cmd", 32'(cmd_valid_o), 32'd0);
        end else begin
          int e;
          e = exp_q.pop_front();
          check("cmd_id", 32'(cmd_id_o), 32'(e));
          check("grant", 32'(grant_o), 32'd1 << e);
        end
      end
      prev_valid = cmd_valid_o;
    end
  end

  // Serve one command: wait for valid, ack after delay, measure lockout.
  task automatic serve(input int delay);
    int n;
    n = 0;
    while (!cmd_valid_o && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("wait_valid", 32'(cmd_valid_o), 32'd1);
    repeat (delay) begin
      @(negedge clk);
      check("valid_held", 32'(cmd_valid_o), 32'd1);
    end
    cmd_ack_i = 1'b1;
    @(negedge clk);
    cmd_ack_i = 1'b0;
    check("valid_drop", 32'(cmd_valid_o), 32'd0);
    n = 0;
    while (busy_o && !cmd_valid_o && n < 64) begin
      n++;
      @(negedge clk);
    end
    check("lockout_len", 32'(n), 32'd16);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset     = 1'b1;
    req_i     = 3'b000;
    cmd_ack_i = 1'b0;
    @(negedge clk);
    check("rst_valid", 32'(cmd_valid_o), 32'd0);
    check("rst_id", 32'(cmd_id_o), 32'd0);
    check("rst_grant", 32'(grant_o), 32'd0);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_ovr", 32'(overrun_o), 32'd0);
    check("rst_tmo", 32'(timeout_o), 32'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Single request: latency, hold of id, ack after 3 cycles, 16-cycle lockout.
    exp_q.push_back(1);
    req_i = 3'b010;
    @(negedge clk);
    check("lat_k", 32'(cmd_valid_o), 32'd0);
    @(negedge clk);
    check("lat_k1", 32'(cmd_valid_o), 32'd1);
    check("lat_busy", 32'(busy_o), 32'd1);
    serve(3);
    check("idle_busy", 32'(busy_o), 32'd0);
    req_i = 3'b000;

    // Simultaneous edges after reset: order 0,1,2.
    do_reset();
    exp_q.push_back(0);
    exp_q.push_back(1);
    exp_q.push_back(2);
    req_i = 3'b111;
    serve(1);
    serve(0);
    serve(2);
    req_i = 3'b000;
    @(negedge clk);

    // Round-robin from last_grant=1 with pending 0 and 2.
    exp_q.push_back(1);
`ifdef CLEAR_PRIORITY_EN
    exp_q.push_back(0);
    exp_q.push_back(2);
`else
    exp_q.push_back(2);
    exp_q.push_back(0);
`endif
    req_i = 3'b010;
    repeat (2) @(negedge clk);
    req_i = 3'b111;
    serve(1);
    serve(1);
    serve(1);
    req_i = 3'b000;
    @(negedge clk);

    // Overrun: second edge on requester 2 while pending, one command only.
    exp_q.push_back(2);
    req_i = 3'b100;
    @(negedge clk);
    req_i = 3'b000;
    @(negedge clk);
    check("ovr_before", 32'(overrun_o), 32'd0);
    req_i = 3'b100;
    @(negedge clk);
    check("ovr_pulse", 32'(overrun_o), 32'd1);
    @(negedge clk);
    check("ovr_single", 32'(overrun_o), 32'd0);
    serve(1);
    repeat (5) @(negedge clk);
    check("ovr_no_reissue", 32'(cmd_valid_o), 32'd0);
    req_i = 3'b000;
    @(negedge clk);

    // Ack timeout after 255 cycles in ISSUE.
    exp_q.push_back(0);
    req_i = 3'b001;
    n = 0;
    while (!cmd_valid_o && n < 10) begin
      @(negedge clk);
      n++;
    end
    n = 0;
    while (cmd_valid_o && n < 300) begin
      check("tmo_early", 32'(timeout_o), 32'd0);
      n++;
      @(negedge clk);
    end
    check("tmo_len", 32'(n), 32'd255);
    check("tmo_pulse", 32'(timeout_o), 32'd1);
    check("tmo_hold", 32'(busy_o), 32'd1);
    @(negedge clk);
    check("tmo_once", 32'(timeout_o), 32'd0);
    n = 0;
    while (busy_o && n < 64) begin
      @(negedge clk);
      n++;
    end
    check("tmo_lockout", 32'(n), 32'd15);
    repeat (5) @(negedge clk);
    check("tmo_cleared", 32'(cmd_valid_o), 32'd0);
    req_i = 3'b000;
    @(negedge clk);

    // Reset mid-ISSUE: async drop, no replay with request held.
    exp_q.push_back(1);
    req_i = 3'b010;
    repeat (2) @(negedge clk);
    check("mid_valid", 32'(cmd_valid_o), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("async_valid", 32'(cmd_valid_o), 32'd0);
    check("async_grant", 32'(grant_o), 32'd0);
    check("async_busy", 32'(busy_o), 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (30) @(negedge clk);
    check("no_replay", 32'(cmd_valid_o), 32'd0);
    check("no_replay_busy", 32'(busy_o), 32'd0);
    req_i = 3'b000;
    @(negedge clk);

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/counter_access_arbiter.md
COUNTER_ACCESS_ARBITER -- requirements
Module: counter_access_arbiter

Interface
REQ-001 Parameter N_REQ, default 3: number of requesters; legal range 2..8.
REQ-002 Parameter LOCKOUT_CYCLES, default 16: idle cycles enforced after each completed command; 0 is legal.
REQ-003 Parameter ACK_TIMEOUT, default 255: cycles to wait for cmd_ack_i before abort; legal range 1..65535.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 req_i  input  N_REQ  per-requester level request from synchronized, debounced buttons.
REQ-007 cmd_valid_o  output  1  command to counter valid.
REQ-008 cmd_id_o  output  clog2(N_REQ)  index of granted requester.
REQ-009 cmd_ack_i  input  1  counter accepted command.
REQ-010 grant_o  output  N_REQ  one-hot copy of cmd_id_o, qualified by cmd_valid_o.
REQ-011 busy_o  output  1  high in any state other than IDLE.
REQ-012 overrun_o  output  1  one-cycle pulse: rising edge on a requester whose pending bit is already set.
REQ-013 timeout_o  output  1  one-cycle pulse: command aborted for missing ack.

Function
REQ-014 Rising-edge detect per bit: edge = req_i & ~prev; prev register resets to all ones, so a request held through reset release does not trigger.
REQ-015 pending[i] sets on edge[i]; clears on the cycle cmd_ack_i is sampled for i or on timeout for i; set wins over clear in the same cycle.
REQ-016 FSM states IDLE, ISSUE, HOLD; reset state IDLE.
REQ-017 IDLE -> ISSUE when any pending bit set; winner = first pending index searching upward from last_grant+1 modulo N_REQ (round-robin); last_grant resets to N_REQ-1.
REQ-018 Latency: req_i first sampled high at edge k -> cmd_valid_o high after edge k+1 (from IDLE).
REQ-019 In ISSUE, cmd_valid_o=1 and cmd_id_o/grant_o held stable until cmd_ack_i=1 is sampled; then cmd_valid_o drops the following cycle, last_grant <= cmd_id_o, go HOLD.
REQ-020 cmd_ack_i outside ISSUE is ignored.
REQ-021 ISSUE timeout: if ACK_TIMEOUT cycles elapse without ack, pulse timeout_o, clear that pending bit, update last_grant, go HOLD.
REQ-022 HOLD counts LOCKOUT_CYCLES cycles then returns to IDLE; with LOCKOUT_CYCLES=0, ISSUE goes directly to IDLE.
REQ-023 Edges arriving during ISSUE/HOLD are recorded in pending and served afterward; none lost unless overrun_o pulses.
REQ-024 Outputs are registered; no combinational path from inputs to outputs.

Reset
REQ-025 On reset assertion, immediately: state IDLE, pending=0, prev=all ones, counters=0, cmd_valid_o=0, cmd_id_o=0, grant_o=0, busy_o=0, overrun_o=0, timeout_o=0.
REQ-026 Reset mid-ISSUE drops cmd_valid_o asynchronously; the interrupted command is discarded, not replayed.

Configuration
REQ-027 Macro CLEAR_PRIORITY_EN: when defined, requester 0 pending always wins in IDLE regardless of last_grant; remaining requesters round-robin among themselves.
REQ-028 Without CLEAR_PRIORITY_EN, all requesters are pure round-robin per REQ-017.

Structure
REQ-029 Package counter_arb_pkg holds the FSM state enum typedef and the default parameter constants.
REQ-030 One sub-module req_edge_detect (prev register plus edge vector, parameterized width); arbitration and FSM stay in the top module.

Verification
REQ-031 Single request: req_i=3'b010 held -> cmd_valid_o high 2 edges later, cmd_id_o=1, ack after 3 cycles -> valid drops next cycle, busy_o high 16 more cycles.
REQ-032 Simultaneous edges req_i=3'b111 from reset -> grant order 0,1,2 with lockout between each.
REQ-033 Round-robin fairness: last_grant=1, pending 0 and 2 -> grant 2 first, then 0; with CLEAR_PRIORITY_EN -> 0 first.
REQ-034 No ack for 255 cycles in ISSUE -> timeout_o one-cycle pulse, pending bit cleared, HOLD entered.
REQ-035 Two edges on req_i[2] while its pending bit is set -> overrun_o pulses on second edge, only one command issued.
REQ-036 Reset asserted mid-ISSUE -> cmd_valid_o low without a clock edge; after release with req_i held high -> no command issued.
